// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit FSM state encoding and the line-level constants used
// by the transmit controller and anything else that drives or checks the pin.
package uart_pkg;

    // Transmit FSM states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Line levels: mark is the idle/stop level, space is the start level.
    localparam logic UART_MARK  = 1'b1;
    localparam logic UART_SPACE = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud period timer.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high during the last cycle of
// each bit period. restart forces the count back to 0 so a new frame's bit
// boundaries line up exactly with its acceptance edge.
//
// Ports:
//   clk     in  1  rising-edge clock
//   reset   in  1  synchronous, active-high
//   restart in  1  synchronous counter restart (count <= 0)
//   tick    out 1  last cycle of the current bit period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller.
// Accepts one byte per valid/ready handshake in IDLE and serialises it as
// start bit, DATA_BITS data bits (LSB first), optional parity, and
// STOP_BITS stop bits. tx is registered and rests at mark.
//
// Handshake: a byte is taken on a rising edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE, so inputs are ignored while a frame runs.
//
// Ports:
//   clk      in  1  rising-edge clock
//   reset    in  1  synchronous, active-high; aborts any frame in progress
//   tx_valid in  1  tx_data holds a byte to send
//   tx_data  in  8  payload; bits [DATA_BITS-1:0] are sent
//   tx_ready out 1  controller is idle and will accept a byte
//   tx       out 1  serial line (registered)
//   busy     out 1  a frame is in progress
//   done     out 1  one-cycle pulse after the last stop bit
import uart_pkg::*;

module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [7:0]       DATA_MASK = 8'(8'hFF >> (8 - DATA_BITS));
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD_SEL   = (PARITY_ODD != 0);
    localparam bit               HAS_PAR   = (PARITY_EN != 0);

    tx_state_e        state;
    tx_state_e        state_next;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic [IDX_W-1:0] bit_idx;
    logic             stop_cnt;
    logic             tick;
    logic             accept;
    logic             tx_next;
    logic             frame_end;
    logic [7:0]       data_used;

    assign tx_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = tx_valid && tx_ready;
    assign data_used = tx_data & DATA_MASK;

    // Restarting on acceptance pins every bit boundary to a multiple of
    // CLKS_PER_BIT from the acceptance edge, independent of idle time.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(accept),
        .tick   (tick)
    );

    // Next state and next line level. tx is registered, so the level for
    // the state being entered is chosen here on the transition edge.
    always_comb begin
        state_next = state;
        tx_next    = UART_MARK;
        frame_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_next = UART_MARK;
                if (accept) begin
                    state_next = ST_START;
                    tx_next    = UART_SPACE;
                end
            end
            ST_START: begin
                tx_next = UART_SPACE;
                if (tick) begin
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                end
            end
            ST_DATA: begin
                tx_next = shift_reg[0];
                if (tick) begin
                    if (bit_idx == IDX_LAST) begin
                        if (HAS_PAR) begin
                            state_next = ST_PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = UART_MARK;
                        end
                    end else begin
                        // Next bit is the one about to be shifted into LSB.
                        tx_next = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                tx_next = parity_bit;
                if (tick) begin
                    state_next = ST_STOP;
                    tx_next    = UART_MARK;
                end
            end
            ST_STOP: begin
                tx_next = UART_MARK;
                if (tick && (stop_cnt == STOP_LAST)) begin
                    state_next = ST_IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = UART_MARK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx         <= UART_MARK;
            done       <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            tx   <= tx_next;
            done <= frame_end;
            if (accept) begin
                shift_reg  <= data_used;
                parity_bit <= (^data_used) ^ ODD_SEL;
                bit_idx    <= '0;
                stop_cnt   <= 1'b0;
            end
            if ((state == ST_DATA) && tick) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 1'b1;
            end
            if ((state == ST_STOP) && tick) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl. Four instances share clk/reset:
//   a : CLKS_PER_BIT=4, 8N1
//   p : CLKS_PER_BIT=4, 8E1
//   o : CLKS_PER_BIT=4, 8O1
//   s : CLKS_PER_BIT=4, 8N2
// Inputs are driven and outputs sampled on the falling edge. Frame
// expectations are hand-written bit strings, bit i = i-th bit on the line.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       valid_a = 1'b0, valid_p = 1'b0, valid_o = 1'b0, valid_s = 1'b0;
    logic [7:0] data_a = 8'h00, data_po = 8'h00, data_s = 8'h00;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_p, tx_p, busy_p, done_p;
    logic       ready_o, tx_o, busy_o, done_o;
    logic       ready_s, tx_s, busy_s, done_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                   .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .tx_valid(valid_a), .tx_data(data_a),
        .tx_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                   .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .clk(clk), .reset(reset), .tx_valid(valid_p), .tx_data(data_po),
        .tx_ready(ready_p), .tx(tx_p), .busy(busy_p), .done(done_p));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                   .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
        .clk(clk), .reset(reset), .tx_valid(valid_o), .tx_data(data_po),
        .tx_ready(ready_o), .tx(tx_o), .busy(busy_o), .done(done_o));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                   .PARITY_ODD(0), .STOP_BITS(2)) dut_s (
        .clk(clk), .reset(reset), .tx_valid(valid_s), .tx_data(data_s),
        .tx_ready(ready_s), .tx(tx_s), .busy(busy_s), .done(done_s));

    // {tx, tx_ready, busy, done} of instance w (0=a 1=p 2=o 3=s)
    function automatic logic [3:0] obs(input int w);
        case (w)
            0:       return {tx_a, ready_a, busy_a, done_a};
            1:       return {tx_p, ready_p, busy_p, done_p};
            2:       return {tx_o, ready_o, busy_o, done_o};
            default: return {tx_s, ready_s, busy_s, done_s};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Called at the falling edge right after acceptance (cycle 0 of frame).
    // Checks tx every cycle and returns at the falling edge after edge E0+N.
    task automatic check_frame(input int w, input logic [15:0] bits,
                               input int nbits, input string name);
        logic [3:0] o;
        o = obs(w);
        check({name, " busy_at_accept"}, o[1], 1'b1);
        check({name, " ready_at_accept"}, o[2], 1'b0);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                o = obs(w);
                check($sformatf("%s tx bit%0d cyc%0d", name, b, c), o[3], bits[b]);
                @(negedge clk);
            end
        end
        o = obs(w);
        check({name, " done_at_end"}, o[0], 1'b1);
        check({name, " ready_at_end"}, o[2], 1'b1);
        check({name, " busy_at_end"}, o[1], 1'b0);
        check({name, " tx_at_end"}, o[3], 1'b1);
    endtask

    initial begin
        logic [3:0] o;
        logic       saw_done;

        // Reset held 3 cycles with a valid byte offered
        valid_a = 1'b1;
        data_a  = 8'h5A;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        valid_a = 1'b0;
        @(negedge clk);
        o = obs(0);
        check("reset tx", o[3], 1'b1);
        check("reset ready", o[2], 1'b1);
        check("reset busy", o[1], 1'b0);
        check("reset done", o[0], 1'b0);
        check("reset s idle", obs(3), 4'b1100);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        valid_a = 1'b1; data_a = 8'hA5;
        @(negedge clk);
        valid_a = 1'b0;
        check_frame(0, 16'h034A, 10, "a5");
        @(negedge clk);
        check("a5 done_one_cycle", obs(0), 4'b1100);

        // Even parity 0x07 -> parity 1
        valid_p = 1'b1; data_po = 8'h07;
        @(negedge clk);
        valid_p = 1'b0;
        check_frame(1, 16'h060E, 11, "even07");
        @(negedge clk);
        check("even07 done_one_cycle", obs(1), 4'b1100);

        // Odd parity 0x07 -> parity 0
        valid_o = 1'b1;
        @(negedge clk);
        valid_o = 1'b0;
        check_frame(2, 16'h040E, 11, "odd07");
        @(negedge clk);
        check("odd07 done_one_cycle", obs(2), 4'b1100);

        // 8N2 back-to-back with valid held: 0x55 then 0xAA
        valid_s = 1'b1; data_s = 8'h55;
        @(negedge clk);
        data_s = 8'hAA;
        check_frame(3, 16'h06AA, 11, "s55");
        @(negedge clk);
        valid_s = 1'b0;
        check_frame(3, 16'h0754, 11, "sAA");
        @(negedge clk);
        check("sAA done_one_cycle", obs(3), 4'b1100);

        // Reset during data bit 3 (frame cycles 16..19)
        valid_a = 1'b1; data_a = 8'hC3;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        o = obs(0);
        check("midreset tx", o[3], 1'b1);
        check("midreset ready", o[2], 1'b1);
        check("midreset busy", o[1], 1'b0);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            o = obs(0);
            if (o[0] !== 1'b0 || o[3] !== 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("midreset no_done_quiet_line", saw_done, 1'b0);

        valid_a = 1'b1; data_a = 8'h3C;
        @(negedge clk);
        valid_a = 1'b0;
        check_frame(0, 16'h0278, 10, "3c");
        @(negedge clk);

        // 0x00 frame, tx_data changed to 0xFF (with valid) during START
        valid_a = 1'b1; data_a = 8'h00;
        @(negedge clk);
        data_a  = 8'hFF;
        @(negedge clk);
        check("chg00 ignores_valid_busy", obs(0), 4'b0010);
        valid_a = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int b = 1; b < 9; b++) begin
            for (int c = 0; c < CPB; c++) begin
                o = obs(0);
                check($sformatf("chg00 tx bit%0d cyc%0d", b, c), o[3], 1'b0);
                @(negedge clk);
            end
        end
        repeat (CPB) @(negedge clk);
        check("chg00 done_at_end", obs(0), 4'b1101);
        @(negedge clk);
        check("chg00 idle_after", obs(0), 4'b1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
